// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive FSM, shift register and consumer handshake
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on serial_in; otherwise a single register stage.
module uart_rx_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       serial_in,
  input  logic       shift_strobe,
  input  logic       packet_done,
  input  logic       data_read,
  output logic       enable_timer,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    STOP_CHK = 2'd2,
    LOAD     = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       serial_sync;
  logic       sync_prev;
  logic       start_det;
  logic [8:0] sr;

`ifdef UART_RX_SYNC_EN
  logic sync_meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_meta   <= 1'b1;
      serial_sync <= 1'b1;
    end else begin
      sync_meta   <= serial_in;
      serial_sync <= sync_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      serial_sync <= 1'b1;
    end else begin
      serial_sync <= serial_in;
    end
  end
`endif

  // Frozen during STOP_CHK/LOAD so a start edge arriving there is still detected back in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_prev <= 1'b1;
    end else if (state != STOP_CHK && state != LOAD) begin
      sync_prev <= serial_sync;
    end
  end

  assign start_det = sync_prev & ~serial_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_det) next_state = RECEIVE;
      RECEIVE:  if (packet_done) next_state = STOP_CHK;
      STOP_CHK: next_state = sr[8] ? LOAD : IDLE;
      LOAD:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  assign enable_timer = (state == RECEIVE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr            <= 9'h1FF;
      rx_data       <= 8'hFF;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (state == RECEIVE && shift_strobe) begin
        sr <= {serial_sync, sr[8:1]};
      end

      if (state == IDLE && start_det) begin
        framing_error <= 1'b0;
      end else if (state == STOP_CHK && !sr[8]) begin
        framing_error <= 1'b1;
      end

      // A read coinciding with LOAD consumes the old byte, so the new one stays ready without overrun.
      if (state == LOAD) begin
        rx_data    <= sr[7:0];
        data_ready <= 1'b1;
        if (data_ready && !data_read) begin
          overrun_error <= 1'b1;
        end
      end else if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a behavioural bit timer
module tb_uart_rx_ctrl;

  logic       clk;
  logic       n_rst;
  logic       serial_in;
  logic       shift_strobe;
  logic       packet_done;
  logic       data_read;
  logic       enable_timer;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       framing_error;
  logic       overrun_error;

  int errors = 0;
  int checks = 0;
  int period = 16;

  uart_rx_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .shift_strobe (shift_strobe),
    .packet_done  (packet_done),
    .data_read    (data_read),
    .enable_timer (enable_timer),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit timer: strobes mid-bit while enabled, packet_done once 10 strobes have elapsed.
  int tcnt = 0;
  int tstrobes = 0;
  initial begin
    shift_strobe = 1'b0;
    packet_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!enable_timer) begin
        tcnt = 0;
        tstrobes = 0;
        shift_strobe = 1'b0;
        packet_done = 1'b0;
      end else begin
        packet_done = (tstrobes >= 10);
        tcnt++;
        shift_strobe = (tstrobes < 10) && ((tcnt % period) == (period / 2));
        if (shift_strobe) tstrobes++;
      end
    end
  end

  logic [7:0] got_q[$];
  logic [7:0] rx_prev = 8'hFF;
  logic       en_prev = 1'b0;
  int         en_rises = 0;
  always @(negedge clk) begin
    if (rx_data !== rx_prev) got_q.push_back(rx_data);
    if (enable_timer && !en_prev) en_rises++;
    rx_prev = rx_data;
    en_prev = enable_timer;
  end

  // Reference model of the consumer-visible state.
  logic [7:0] m_rx;
  logic       m_rdy;
  logic       m_fe;
  logic       m_ov;

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic rd_in_load);
    m_fe = !stop;
    if (stop) begin
      if (m_rdy && !rd_in_load) m_ov = 1'b1;
      m_rx  = d;
      m_rdy = 1'b1;
    end
  endtask

  task automatic model_read();
    if (m_rdy) begin
      m_rdy = 1'b0;
      m_ov  = 1'b0;
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len, input int gap);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat ((i == 9) ? stop_len : period) @(posedge clk);
      #1;
    end
    serial_in = 1'b1;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      if (packet_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_read();
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
    model_read();
  endtask

  // One frame with end-of-frame timing checks; optionally pulses data_read in the LOAD cycle.
  task automatic run_frame(input logic [7:0] d, input logic stop, input int gap, input bit rd_in_load);
    bit ok;
    fork
      send_frame(d, stop, period, gap);
      begin
        wait_pd(ok);
        chk1("pd_seen", ok, 1'b1);
        if (ok) begin
          chk1("fe_clear_in_rx", framing_error, 1'b0);
          @(posedge clk);
          #1;
          chk1("en_off_stopchk", enable_timer, 1'b0);
          @(posedge clk);
          #1;
          chk1("fe_after_stopchk", framing_error, !stop);
          if (rd_in_load && stop) data_read = 1'b1;
          @(posedge clk);
          #1;
          data_read = 1'b0;
        end
      end
    join
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd_after;
    logic [7:0] exp_rx;
    logic       exp_rdy;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit         ok;
    int         base;
    int         r0;
    logic [7:0] d;
    logic       st;
    logic       rdl;

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1};

    n_rst = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_en", enable_timer, 1'b0);
    chk8("rst_rx", rx_data, 8'hFF);
    chk1("rst_rdy", data_ready, 1'b0);
    chk1("rst_fe", framing_error, 1'b0);
    chk1("rst_ov", overrun_error, 1'b0);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Valid frame at the real bit period, with exact data_ready latency.
    period = 434;
    fork
      send_frame(8'hA5, 1'b1, 434, 4);
      begin
        wait_pd(ok);
        chk1("a5_pd_seen", ok, 1'b1);
        chk1("a5_rdy_p0", data_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("a5_en_off", enable_timer, 1'b0);
        chk1("a5_rdy_p1", data_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("a5_rdy_p2", data_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("a5_rdy_p3", data_ready, 1'b1);
        chk8("a5_rx", rx_data, 8'hA5);
        chk1("a5_fe", framing_error, 1'b0);
      end
    join
    period = 16;
    do_read();
    chk1("a5_read_rdy", data_ready, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].stop, 4, 1'b0);
      chk8("vec_rx", rx_data, vecs[i].exp_rx);
      chk1("vec_rdy", data_ready, vecs[i].exp_rdy);
      chk1("vec_fe", framing_error, vecs[i].exp_fe);
      chk1("vec_ov", overrun_error, vecs[i].exp_ov);
      if (vecs[i].rd_after) begin
        do_read();
        chk1("vec_read_rdy", data_ready, 1'b0);
        chk1("vec_read_ov", overrun_error, 1'b0);
      end
    end

    // Read landing in the LOAD cycle of the second byte.
    run_frame(8'h66, 1'b1, 4, 1'b0);
    chk8("sim_first_rx", rx_data, 8'h66);
    run_frame(8'h77, 1'b1, 4, 1'b1);
    chk8("sim_rx", rx_data, 8'h77);
    chk1("sim_rdy", data_ready, 1'b1);
    chk1("sim_ov", overrun_error, 1'b0);
    do_read();

    // Back-to-back: the second start edge arrives while the first frame is in LOAD.
    base = got_q.size();
    r0 = en_rises;
    send_frame(8'h00, 1'b1, 11, 0);
    send_frame(8'hFF, 1'b1, 16, 6);
    chk1("b2b_count", (got_q.size() - base) == 2, 1'b1);
    if (got_q.size() >= base + 2) begin
      chk8("b2b_first", got_q[base], 8'h00);
      chk8("b2b_second", got_q[base+1], 8'hFF);
    end
    chk1("b2b_en_rises", (en_rises - r0) == 2, 1'b1);
    chk8("b2b_rx", rx_data, 8'hFF);
    chk1("b2b_ov", overrun_error, 1'b1);
    do_read();

    // Reset mid-frame while a byte is pending, then a clean frame.
    run_frame(8'h3E, 1'b1, 4, 1'b0);
    fork
      send_frame(8'h5B, 1'b1, 16, 4);
      begin
        repeat (60) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk1("mrst_en", enable_timer, 1'b0);
        chk8("mrst_rx", rx_data, 8'hFF);
        chk1("mrst_rdy", data_ready, 1'b0);
        chk1("mrst_fe", framing_error, 1'b0);
        chk1("mrst_ov", overrun_error, 1'b0);
      end
    join
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("mrst_idle_rdy", data_ready, 1'b0);
    run_frame(8'h96, 1'b1, 4, 1'b0);
    chk8("post_rst_rx", rx_data, 8'h96);
    chk1("post_rst_rdy", data_ready, 1'b1);
    do_read();

    m_rx = 8'h96;
    m_rdy = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      rdl = st && !m_ov && m_rdy && ($urandom_range(0, 2) == 0);
      run_frame(d, st, $urandom_range(2, 10), rdl);
      model_frame(d, st, rdl);
      chk8("rnd_rx", rx_data, m_rx);
      chk1("rnd_rdy", data_ready, m_rdy);
      chk1("rnd_fe", framing_error, m_fe);
      chk1("rnd_ov", overrun_error, m_ov);
      if ($urandom_range(0, 2) == 0) begin
        do_read();
        chk1("rnd_read_rdy", data_ready, m_rdy);
        chk1("rnd_read_ov", overrun_error, m_ov);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
